// File: rtl/spi_byte_sequencer_if.sv
// rtl/spi_byte_sequencer_if.sv - host-side and SPI-master-side signals of the byte sequencer
interface spi_byte_sequencer_if #(
    parameter int bus_width = 8,
    parameter int DEPTH     = 8
);
    logic                   i_Wr_En;
    logic [bus_width-1:0]   i_Wr_Data;
    logic                   o_TX_Full;
    logic [$clog2(DEPTH):0] o_TX_Count;
    logic                   i_Rd_En;
    logic [bus_width-1:0]   o_Rd_Data;
    logic                   o_RX_Empty;
    logic                   o_Busy;
    logic                   o_TX_Ovf;
    logic                   o_RX_Ovf;
    logic                   i_Flag_Clr;
    logic                   o_TX_DV;
    logic [bus_width-1:0]   o_TX_Byte;
    logic                   i_TX_Ready;
    logic [bus_width-1:0]   i_RX_Byte;

    // slave: the sequencer itself; master: whatever drives it (host plus SPI master)
    modport slave (
        input  i_Wr_En, i_Wr_Data, i_Rd_En, i_Flag_Clr, i_TX_Ready, i_RX_Byte,
        output o_TX_Full, o_TX_Count, o_Rd_Data, o_RX_Empty, o_Busy,
               o_TX_Ovf, o_RX_Ovf, o_TX_DV, o_TX_Byte
    );

    modport master (
        output i_Wr_En, i_Wr_Data, i_Rd_En, i_Flag_Clr, i_TX_Ready, i_RX_Byte,
        input  o_TX_Full, o_TX_Count, o_Rd_Data, o_RX_Empty, o_Busy,
               o_TX_Ovf, o_RX_Ovf, o_TX_DV, o_TX_Byte
    );
endinterface

// File: rtl/spi_byte_sequencer.sv
// rtl/spi_byte_sequencer.sv - TX/RX byte FIFOs feeding an SPI master over its DV/ready handshake
module spi_byte_sequencer #(
    parameter int bus_width = 8,
    parameter int DEPTH     = 8
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    spi_byte_sequencer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
    state_t state;

    logic [bus_width-1:0] tx_mem [DEPTH];
    logic [bus_width-1:0] rx_mem [DEPTH];

    logic [PW-1:0]        tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0]        tx_count, rx_count;
    logic                 tx_full_q, rx_empty_q, busy_q, tx_dv_q, tx_ovf_q, rx_ovf_q;
    logic [bus_width-1:0] tx_byte_q, rd_data_q;

    logic                 tx_pop, tx_push, tx_ovf_set;
    logic                 rx_cap, rx_pop, rx_push, rx_ovf_set;
    logic [CW-1:0]        tx_count_nxt, rx_count_nxt;
    logic [PW-1:0]        rx_rd_ptr_nxt;
    logic [bus_width-1:0] rx_head_nxt;

    always_comb begin
        tx_pop       = (state == IDLE) && (tx_count != '0) && bus.i_TX_Ready;
        // a same-cycle pop frees the slot, so a push into a full FIFO is still accepted
        tx_push      = bus.i_Wr_En && ((tx_count != FULL_CNT) || tx_pop);
        tx_ovf_set   = bus.i_Wr_En && (tx_count == FULL_CNT) && !tx_pop;
        tx_count_nxt = tx_count + CW'(tx_push) - CW'(tx_pop);

        rx_cap       = (state == WAIT_DONE) && bus.i_TX_Ready;
        rx_pop       = bus.i_Rd_En && (rx_count != '0);
        rx_push      = rx_cap && ((rx_count != FULL_CNT) || rx_pop);
        rx_ovf_set   = rx_cap && (rx_count == FULL_CNT) && !rx_pop;
        rx_count_nxt = rx_count + CW'(rx_push) - CW'(rx_pop);

        // Head after this edge: the byte being written if it lands at the new read slot
        rx_rd_ptr_nxt = rx_rd_ptr + PW'(rx_pop);
        rx_head_nxt   = (rx_push && (rx_rd_ptr_nxt == rx_wr_ptr)) ? bus.i_RX_Byte
                                                                   : rx_mem[rx_rd_ptr_nxt];
    end

    always_ff @(posedge i_Clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= bus.i_Wr_Data;
        if (rx_push) rx_mem[rx_wr_ptr] <= bus.i_RX_Byte;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state      <= IDLE;
            tx_wr_ptr  <= '0;
            tx_rd_ptr  <= '0;
            rx_wr_ptr  <= '0;
            rx_rd_ptr  <= '0;
            tx_count   <= '0;
            rx_count   <= '0;
            tx_full_q  <= 1'b0;
            rx_empty_q <= 1'b1;
            busy_q     <= 1'b0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= '0;
            rd_data_q  <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_pop) begin
                        state  <= WAIT_BUSY;
                        busy_q <= 1'b1;
                    end
                end
                WAIT_BUSY: begin
                    if (!bus.i_TX_Ready) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.i_TX_Ready) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase

            tx_dv_q <= tx_pop;
            if (tx_pop) tx_byte_q <= tx_mem[tx_rd_ptr];

            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
            tx_count  <= tx_count_nxt;
            tx_full_q <= (tx_count_nxt == FULL_CNT);

            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
            rx_rd_ptr  <= rx_rd_ptr_nxt;
            rx_count   <= rx_count_nxt;
            rx_empty_q <= (rx_count_nxt == '0);
            if (rx_count_nxt != '0) rd_data_q <= rx_head_nxt;

            tx_ovf_q <= bus.i_Flag_Clr ? 1'b0 : (tx_ovf_q | tx_ovf_set);
            rx_ovf_q <= bus.i_Flag_Clr ? 1'b0 : (rx_ovf_q | rx_ovf_set);
        end
    end

    assign bus.o_TX_Full  = tx_full_q;
    assign bus.o_TX_Count = tx_count;
    assign bus.o_Rd_Data  = rd_data_q;
    assign bus.o_RX_Empty = rx_empty_q;
    assign bus.o_Busy     = busy_q;
    assign bus.o_TX_Ovf   = tx_ovf_q;
    assign bus.o_RX_Ovf   = rx_ovf_q;
    assign bus.o_TX_DV    = tx_dv_q;
    assign bus.o_TX_Byte  = tx_byte_q;
endmodule
